// File: rtl/call_return_ctrl.sv
// call_return_ctrl: sequences CALL/RET requests onto the return-address stack.
// Each accepted request yields exactly one push or pop strobe plus a PC load,
// then two settle cycles so the stack's registered flags and top entry are
// valid again before the controller accepts the next request.
module call_return_ctrl #(
    parameter logic [31:0] RET_OFFSET = 32'd1,
    parameter logic [3:0]  DEPTH      = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic [31:0] pc_current,
    input  logic [31:0] call_target,
    input  logic [31:0] stack_top,
    input  logic        stack_empty,
    input  logic        stack_full,
    output logic        stack_push,
    output logic        stack_pop,
    output logic [31:0] stack_wdata,
    output logic [31:0] pc_next,
    output logic        pc_load,
    output logic        ready,
    output logic        done,
    output logic        overflow_err,
    output logic        underflow_err,
    output logic [3:0]  depth
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CALL_OP = 3'd1;
    localparam logic [2:0] RET_OP  = 3'd2;
    localparam logic [2:0] SETTLE1 = 3'd3;
    localparam logic [2:0] SETTLE2 = 3'd4;
    localparam logic [2:0] ERR     = 3'd5;

    logic [2:0] state;

    // Sequencer: accept a request in IDLE, latch its data, walk the settle chain.
    // The return address and target are latched straight into the stack_wdata
    // and pc_next registers at accept time, so both are stable throughout the
    // strobe cycle and pc_next holds its last value on the error path.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; blocking here would create order-dependent races.
        if (rst) begin
            state         <= IDLE;
            stack_wdata   <= 32'd0;
            pc_next       <= 32'd0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            depth         <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    // CALL wins over a simultaneous RET; the RET is dropped.
                    if (call_req) begin
                        if (!stack_full) begin
                            stack_wdata <= pc_current + RET_OFFSET;
                            pc_next     <= call_target;
                            if (depth != DEPTH) begin
                                depth <= depth + 4'd1;
                            end
                            state <= CALL_OP;
                        end else begin
                            overflow_err <= 1'b1;
                            state        <= ERR;
                        end
                    end else if (ret_req) begin
                        if (!stack_empty) begin
                            pc_next <= stack_top;
                            if (depth != 4'd0) begin
                                depth <= depth - 4'd1;
                            end
                            state <= RET_OP;
                        end else begin
                            underflow_err <= 1'b1;
                            state         <= ERR;
                        end
                    end
                end
                CALL_OP: state <= SETTLE1;
                RET_OP:  state <= SETTLE1;
                SETTLE1: state <= SETTLE2;
                SETTLE2: state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode: strobes and status are pure functions of the registered state.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block
        // leaves a value unassigned, which would infer a latch.
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        pc_load    = 1'b0;
        done       = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            CALL_OP: begin
                stack_push = 1'b1;
                pc_load    = 1'b1;
            end
            RET_OP: begin
                stack_pop = 1'b1;
                pc_load   = 1'b1;
            end
            SETTLE2: done = 1'b1;
            ERR:     done = 1'b1;
            default: ;
        endcase
    end

endmodule
